// File: rtl/muldiv_pkg.sv
// Shared types and Funct3 decode for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  // Upper half of the Funct3 space is divide/remainder.
  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] funct3);
    return (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
           (funct3 == F3_DIV)  || (funct3 == F3_REM);
  endfunction

  // rs2 is interpreted as signed for MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] funct3);
    return (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final correction stage: re-applies operand signs to the magnitude result
// held in the accumulator and selects the architectural word.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic              a_neg_i,
  input  logic              b_neg_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // Negate product/quotient on differing signs; remainder follows the dividend.
  always_comb begin
    prod = (a_neg_i ^ b_neg_i) ? -acc_i : acc_i;
    quot = (a_neg_i ^ b_neg_i) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
    rem  = a_neg_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
    result_o = '0;
    if (!is_div(funct3_i)) begin
      result_o = (funct3_i == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      result_o = funct3_i[1] ? rem : quot;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and
// restoring divide on operand magnitudes, with a sign-fix cycle at the end.
// Optional macro MULDIV_ZERO_SKIP_EN: multiplies with a zero operand finish
// through the single-cycle fast path.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   op_q;
  logic [2:0]        f3_q;
  logic              a_neg_q, b_neg_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic              a_neg_d, b_neg_d;
  logic [XLEN-1:0]   a_mag_d, b_mag_d;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [XLEN-1:0]   fix_res;

  // Launch decode on the live inputs: sign flags, magnitudes and fast-path result.
  always_comb begin
    a_neg_d  = a_is_signed(Funct3) & SrcA[XLEN-1];
    b_neg_d  = b_is_signed(Funct3) & SrcB[XLEN-1];
    a_mag_d  = a_neg_d ? -SrcA : SrcA;
    b_mag_d  = b_neg_d ? -SrcB : SrcB;
    fast_hit = 1'b0;
    fast_res = '0;
    if (is_div(Funct3)) begin
      if (SrcB == '0) begin
        fast_hit = 1'b1;
        fast_res = Funct3[1] ? SrcA : '1;
      end else if (a_is_signed(Funct3) && (SrcA == INT_MIN) && (SrcB == '1)) begin
        fast_hit = 1'b1;
        fast_res = Funct3[1] ? '0 : INT_MIN;
      end
    end
`ifdef MULDIV_ZERO_SKIP_EN
    else if ((SrcA == '0) || (SrcB == '0)) begin
      fast_hit = 1'b1;
      fast_res = '0;
    end
`endif
  end

  // One loop iteration: multiply keeps {carry,hi} + multiplicand shifting right,
  // divide shifts left and keeps the trial subtract when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, op_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, op_q};
    div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .funct3_i (f3_q),
    .acc_i    (acc_q),
    .a_neg_i  (a_neg_q),
    .b_neg_i  (b_neg_q),
    .result_o (fix_res)
  );

  // Sequencer: state, datapath registers and registered busy/done/Result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            f3_q    <= Funct3;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (fast_hit) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              // Multiply iterates over the multiplier in the low word;
              // divide iterates over the dividend.
              acc_q   <= is_div(Funct3) ? {{XLEN{1'b0}}, a_mag_d} : {{XLEN{1'b0}}, b_mag_d};
              op_q    <= is_div(Funct3) ? b_mag_d : a_mag_d;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= is_div(f3_q) ? div_next : mul_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) state_q <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against an arithmetic RV32M model.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M semantics straight from the ISA rules using wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    int     ia = $signed(a);
    int     ib = $signed(b);
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
    if (!f3[2] && (a == 0 || b == 0)) return 1;
`endif
    return 34;
  endfunction

  // Launch one op in cycle 0, scramble inputs while busy, return done cycle and
  // Result; leaves the bench one cycle after done (DUT back in IDLE).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output int lat, output logic [31:0] res, output bit busy_ok);
    Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    start = poke; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      start = poke; SrcA = $urandom; SrcB = $urandom;
    end
    if (!done) lat = -1;
    res = Result;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (Result !== 32'd0) begin fails++; $display("FAIL reset_result got=%h exp=0", Result); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          el  [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
    int lat; logic [31:0] res; bit bok;
    for (int i = 0; i < 12; i++) begin
      run_op(f3s[i], as[i], bs[i], 1'b0, lat, res, bok);
      tests++; if (res !== ex[i]) begin fails++; $display("FAIL directed%0d_result got=%h exp=%h", i, res, ex[i]); end
      tests++; if (lat != el[i]) begin fails++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
      if (el[i] == 34) begin
        tests++; if (!bok) begin fails++; $display("FAIL directed%0d_busy got=low exp=high cycles 1-33", i); end
      end
    end
  endtask

  task automatic test_zero_operand();
    int lat; logic [31:0] res; bit bok;
    run_op(3'd0, 32'd0, 32'h1234_5678, 1'b0, lat, res, bok);
    tests++; if (res !== 32'd0) begin fails++; $display("FAIL zero_mul_result got=%h exp=0", res); end
    tests++; if (lat != model_lat(3'd0, 32'd0, 32'h1234_5678)) begin
      fails++; $display("FAIL zero_mul_latency got=%0d exp=%0d", lat, model_lat(3'd0, 32'd0, 32'h1234_5678)); end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; bit bok; int seen;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, res, bok);
    Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got=%b exp=0", busy); end
    seen = 0;
    repeat (40) begin if (done) seen++; @(posedge clk); #1; end
    tests++; if (seen != 0) begin fails++; $display("FAIL flush_done got=%0d pulses exp=0", seen); end
    tests++; if (Result !== 32'hFFFF_FFFE) begin fails++; $display("FAIL flush_result got=%h exp=fffffffe", Result); end
    Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_flush_idle_busy got=%b exp=0", busy); end
    seen = 0;
    repeat (40) begin if (done || busy) seen++; @(posedge clk); #1; end
    tests++; if (seen != 0) begin fails++; $display("FAIL start_flush_idle_activity got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; bit bok; logic [31:0] a, b;
    Funct3 = 3'd5; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done got=%b exp=0", done); end
    tests++; if (Result !== 32'd0) begin fails++; $display("FAIL midreset_result got=%h exp=0", Result); end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    a = $urandom; b = $urandom_range(1, 1000);
    run_op(3'd4, a, b, 1'b0, lat, res, bok);
    tests++; if (res !== model(3'd4, a, b)) begin fails++; $display("FAIL midreset_rerun got=%h exp=%h", res, model(3'd4, a, b)); end
    tests++; if (lat != 34) begin fails++; $display("FAIL midreset_rerun_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; bit bok;
    logic [2:0] f3s [3] = '{3'd1, 3'd7, 3'd4};
    logic [31:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      if (i == 2) b = 32'd0;
      run_op(f3s[i], a, b, 1'b1, lat, res, bok);
      tests++; if (res !== model(f3s[i], a, b)) begin fails++; $display("FAIL b2b%0d_result got=%h exp=%h", i, res, model(f3s[i], a, b)); end
      tests++; if (lat != model_lat(f3s[i], a, b)) begin fails++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, model_lat(f3s[i], a, b)); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b%0d_start_in_done got busy=%b exp=0", i, busy); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; bit bok;
    logic [2:0] f3; logic [31:0] a, b;
    logic [31:0] corner [4] = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
    for (int i = 0; i < 48; i++) begin
      f3 = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      run_op(f3, a, b, 1'b0, lat, res, bok);
      tests++; if (res !== model(f3, a, b)) begin
        fails++; $display("FAIL random%0d f3=%0d a=%h b=%h got=%h exp=%h", i, f3, a, b, res, model(f3, a, b)); end
      tests++; if (lat != model_lat(f3, a, b)) begin
        fails++; $display("FAIL random%0d_latency got=%0d exp=%0d", i, lat, model_lat(f3, a, b)); end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_zero_operand();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per start pulse and runs a 32-step shift-add (multiply) or restoring-subtract (divide) loop on an internal 64-bit accumulator.
- Busy stalls the pipeline; done presents the 32-bit result for exactly one cycle.
- Selection uses the same Funct3 field the ALU controller decodes, qualified by Funct7 = 0000001 upstream.

Parameters:
- XLEN, 32, operand/result width (only 32 supported; iteration count = XLEN).
- CNT_W, 5, iteration counter width ($clog2(XLEN)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- start  in  1  launch request; sampled only in IDLE.
- flush  in  1  pipeline kill; aborts any operation in flight.
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  32  rs1 operand (multiplicand/dividend); captured at start.
- SrcB  in  32  rs2 operand (multiplier/divisor); captured at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle result-valid pulse.
- Result  out  32  operation result; held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, Result=0, state=IDLE, counter=0, accumulator=0.
- States and transitions:
  - IDLE: start=1 and flush=0 -> latch Funct3, operand magnitudes and sign flags -> CALC, or DONE on a fast path.
  - CALC: counter 0..31, one iteration per cycle; counter==31 -> FIX.
  - FIX: applies two's-complement correction and selects the low/high word -> DONE.
  - DONE: done=1, Result valid -> IDLE.
- Normal latency, start cycle = cycle 0: CALC cycles 1-32, FIX cycle 33, done=1 in cycle 34.
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats SrcA signed, SrcB unsigned.
  - MULHU, DIVU and REMU are unsigned.
  - The loop always runs on magnitudes.
- Sign rules:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- MUL returns product[31:0]; MULH* return product[63:32].
- Fast paths take IDLE -> DONE, so done=1 in cycle 1:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> SrcA.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF, DIV) -> 0x80000000; REM -> 0.
- Handshake:
  - start in any non-IDLE state is ignored; no queueing.
  - start in DONE is also ignored; the requester re-asserts after done.
- Flush:
  - In CALC/FIX/DONE: next state IDLE, done suppressed, Result unchanged.
  - flush and start together in IDLE: flush wins and nothing is launched.
- Reset asserted mid-operation: immediate return to the reset values; no done is emitted.
- Operands are registered at start, so SrcA/SrcB/Funct3 may change freely while busy.

Optional Feature:
- Macro MULDIV_ZERO_SKIP_EN.
- Defined: multiply with SrcA==0 or SrcB==0 takes the fast path (Result=0, done in cycle 1).
- Undefined: zero operands run the full 34-cycle sequence and produce identical results.

Decomposition:
- muldiv_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;
  - localparams for the eight Funct3 encodings and MULDIV_FUNCT7=7'b0000001;
  - helper function is_div(funct3).
- Sub-module muldiv_sign_fix: combinational negate/word-select used in FIX, which keeps the FSM file focused on sequencing.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD -> Result=0xFFFFFFEB, done in cycle 34, busy high cycles 1-33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with done in cycle 1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Flush in cycle 10 of a MUL -> busy=0 in cycle 11, no done pulse, Result keeps the prior value; start+flush in IDLE -> stays IDLE.
- Reset low in cycle 20 of a DIV -> busy/done/Result=0 immediately; a new start after reset releases gives the correct result in cycle 34; start pulses while busy are ignored.
